zap_wb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone B3 arbiter. It lets the code-side bus (M0) and the data-side bus (M1) share a single slave port, e.g. one port of model_ram_dual or an external memory controller.
- Grants are round-robin and held for the whole CYC tenure, including CTI incrementing bursts.
- Registered grant gives 1 cycle of arbitration latency.

---
 rtl/zap_wb_arb_pkg.sv | 23 ++
 rtl/zap_wb_arb_rr.sv | 20 ++
 rtl/zap_wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_zap_wb_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone B3 arbiter: cycle-type codes,
// FSM state encoding and the state-to-grant decode.
package zap_wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  function automatic logic [1:0] gnt_of(arb_state_t s);
    case (s)
      GNT0:    return 2'b01;
      GNT1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/zap_wb_arb_rr.sv
// Two-way round-robin pick: one-hot next grant from the request pair and the
// index of the master that held the bus last (last=1 means M1, so M0 wins ties).
module zap_wb_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves gnt unassigned (no latch).
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/zap_wb_arbiter.sv
// Two-master, one-slave Wishbone B3 arbiter with registered round-robin grant held
// for the whole CYC tenure. Optional ACK watchdog enabled by ZAP_WB_ARB_WDOG_EN.
module zap_wb_arbiter
  import zap_wb_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  // M0: code side
  input  logic                  i_m0_cyc,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_we,
  input  logic [ADDR_W-1:0]     i_m0_adr,
  input  logic [DATA_W/8-1:0]   i_m0_sel,
  input  logic [DATA_W-1:0]     i_m0_dat,
  input  logic [2:0]            i_m0_cti,
  output logic [DATA_W-1:0]     o_m0_dat,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  // M1: data side
  input  logic                  i_m1_cyc,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_we,
  input  logic [ADDR_W-1:0]     i_m1_adr,
  input  logic [DATA_W/8-1:0]   i_m1_sel,
  input  logic [DATA_W-1:0]     i_m1_dat,
  input  logic [2:0]            i_m1_cti,
  output logic [DATA_W-1:0]     o_m1_dat,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  // Slave port
  output logic                  o_s_cyc,
  output logic                  o_s_stb,
  output logic                  o_s_we,
  output logic [ADDR_W-1:0]     o_s_adr,
  output logic [DATA_W/8-1:0]   o_s_sel,
  output logic [DATA_W-1:0]     o_s_dat,
  output logic [2:0]            o_s_cti,
  input  logic [DATA_W-1:0]     i_s_dat,
  input  logic                  i_s_ack,
  // Status
  output logic [1:0]            o_gnt,
  output logic                  o_wdog_trip
);

  if (WDOG_CYCLES < 2) begin : g_wdog_cfg_bad
    $error("zap_wb_arbiter: WDOG_CYCLES must be at least 2");
  end

  arb_state_t state;
  logic       last;
  logic [1:0] req;
  logic [1:0] pick;
  logic       wdog_hit;
  logic       release_bus;

  assign req = {i_m1_cyc & i_m1_stb, i_m0_cyc & i_m0_stb};

  zap_wb_arb_rr u_rr (
    .req  (req),
    .last (last),
    .gnt  (pick)
  );

  // Slave side follows the owner combinationally; everything is quiet in IDLE.
  always_comb begin
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    o_s_we  = 1'b0;
    o_s_adr = '0;
    o_s_sel = '0;
    o_s_dat = '0;
    o_s_cti = CTI_CLASSIC;
    case (state)
      GNT0: begin
        o_s_cyc = i_m0_cyc;
        o_s_stb = i_m0_stb;
        o_s_we  = i_m0_we;
        o_s_adr = i_m0_adr;
        o_s_sel = i_m0_sel;
        o_s_dat = i_m0_dat;
        o_s_cti = i_m0_cti;
      end
      GNT1: begin
        o_s_cyc = i_m1_cyc;
        o_s_stb = i_m1_stb;
        o_s_we  = i_m1_we;
        o_s_adr = i_m1_adr;
        o_s_sel = i_m1_sel;
        o_s_dat = i_m1_dat;
        o_s_cti = i_m1_cti;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the owner ever sees ACK, so IDLE ACKs vanish.
  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;
  assign o_m0_ack = (state == GNT0) & i_s_ack;
  assign o_m1_ack = (state == GNT1) & i_s_ack;

  // Tenure ends on CYC drop (also covers burst abort), on the EOB ACK, or on a watchdog trip.
  assign release_bus = (state != IDLE) &
                       (~o_s_cyc | (i_s_ack & (o_s_cti == CTI_EOB)) | wdog_hit);

`ifdef ZAP_WB_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] wdog_cnt;
  logic             trip_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wdog_cnt <= '0;
      trip_q   <= 1'b0;
    end else begin
      if (state == IDLE || i_s_ack) wdog_cnt <= '0;
      else if (o_s_stb)             wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_hit)                 trip_q   <= 1'b1;
    end
  end

  assign wdog_hit    = (state != IDLE) & o_s_stb & ~i_s_ack & (wdog_cnt == WDOG_LAST);
  assign o_m0_err    = wdog_hit & (state == GNT0);
  assign o_m1_err    = wdog_hit & (state == GNT1);
  assign o_wdog_trip = trip_q;
`else
  assign wdog_hit    = 1'b0;
  assign o_m0_err    = 1'b0;
  assign o_m1_err    = 1'b0;
  assign o_wdog_trip = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments; reset asserts asynchronously.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      o_gnt <= 2'b00;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pick == 2'b01) begin
            state <= GNT0;
            o_gnt <= gnt_of(GNT0);
          end else if (pick == 2'b10) begin
            state <= GNT1;
            o_gnt <= gnt_of(GNT1);
          end
        end
        GNT0, GNT1: begin
          if (release_bus) begin
            state <= IDLE;
            o_gnt <= 2'b00;
            last  <= (state == GNT1);
          end
        end
        default: begin
          state <= IDLE;
          o_gnt <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Self-checking bench for zap_wb_arbiter: an owner/last bus model checked every cycle,
// plus directed scenarios with literal expectations. Watchdog case needs ZAP_WB_ARB_WDOG_EN.
module tb_zap_wb_arbiter;
  import zap_wb_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int WDOG = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [SW-1:0] m0_sel, m1_sel;
  logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat;
  logic [2:0]    m0_cti, m1_cti;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_wdat, s_rdat;
  logic [2:0]    s_cti;
  logic [1:0]    gnt;
  logic          trip;

  zap_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(WDOG)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
    .i_m0_sel(m0_sel), .i_m0_dat(m0_wdat), .i_m0_cti(m0_cti),
    .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
    .i_m1_sel(m1_sel), .i_m1_dat(m1_wdat), .i_m1_cti(m1_cti),
    .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
    .o_s_sel(s_sel), .o_s_dat(s_wdat), .o_s_cti(s_cti),
    .i_s_dat(s_rdat), .i_s_ack(s_ack),
    .o_gnt(gnt), .o_wdog_trip(trip)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus model: who owns the slave (-1 none), who owned it last, stall count, trip flag.
  int owner  = -1;
  int last_m = 1;
  int stall  = 0;
  bit trip_m = 1'b0;

  function automatic logic [73:0] master_bus(input int m);
    if (m == 0) return {m0_cyc, m0_stb, m0_we, m0_cti, m0_sel, m0_adr, m0_wdat};
    if (m == 1) return {m1_cyc, m1_stb, m1_we, m1_cti, m1_sel, m1_adr, m1_wdat};
    return '0;
  endfunction

  always @(negedge clk) begin
    logic [73:0] e_bus;
    logic [1:0]  e_gnt;
    bit          hit;
    bit          r0, r1;
    if (!rst_n) begin
      owner = -1; last_m = 1; stall = 0; trip_m = 1'b0;
    end
    e_bus = master_bus(owner);
    e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    hit   = 1'b0;
`ifdef ZAP_WB_ARB_WDOG_EN
    hit = rst_n && owner >= 0 && e_bus[72] && !s_ack && (stall + 1 == WDOG);
`endif
    check("gnt", 128'(gnt), 128'(e_gnt));
    check("slave_bus", 128'({s_cyc, s_stb, s_we, s_cti, s_sel, s_adr, s_wdat}), 128'(e_bus));
    check("m_term", 128'({m0_ack, m0_err, m1_ack, m1_err}),
          128'({owner == 0 && s_ack, hit && owner == 0, owner == 1 && s_ack, hit && owner == 1}));
    check("m_rdata", 128'({m0_rdat, m1_rdat}), 128'({s_rdat, s_rdat}));
    check("wdog_trip", 128'(trip), 128'(trip_m));
    if (rst_n) begin
      if (owner < 0) begin
        stall = 0;
        r0 = m0_cyc && m0_stb;
        r1 = m1_cyc && m1_stb;
        if (r0 && r1) owner = 1 - last_m;
        else if (r0)  owner = 0;
        else if (r1)  owner = 1;
      end else begin
        if (s_ack)          stall = 0;
        else if (e_bus[72]) stall++;
        if (hit) trip_m = 1'b1;
        if (hit || !e_bus[73] || (s_ack && e_bus[70:68] == CTI_EOB)) begin
          last_m = owner; owner = -1; stall = 0;
        end
      end
    end
  end

  // Stimulus side: values sampled on the falling edge, inputs driven 1 after the rising edge.
  bit          slave_on = 1'b1;
  bit          seen_stb, seen_sack, seen_ack0, seen_ack1, seen_err0, m1_ack_any;
  logic [DW-1:0] seen_rdat0;

  task automatic step();
    @(negedge clk);
    seen_stb   = s_stb;
    seen_sack  = s_ack;
    seen_ack0  = m0_ack;
    seen_ack1  = m1_ack;
    seen_err0  = m0_err;
    seen_rdat0 = m0_rdat;
    if (m1_ack) m1_ack_any = 1'b1;
    @(posedge clk);
    #1;
    s_ack = slave_on && seen_stb && !seen_sack;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [2:0] cti);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_cti = cti;
    m0_sel = 4'hF; m0_wdat = 32'h0C0D_0000 ^ adr;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [2:0] cti);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_cti = cti;
    m1_sel = 4'h3; m1_wdat = 32'hDA7A_0000 ^ adr;
  endtask

  task automatic wait_ack(input int m, input int max, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < max) begin
      step();
      n++;
      if (m == 0 ? seen_ack0 : seen_ack1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_ack = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  n, beats, viol, cnt0, cnt1, alt_err, tenures;
    bit  ok, err_any;
    logic [1:0] prev_gnt;
    int  seq [20];

    set_m0(0, 0, 0, '0, CTI_CLASSIC);
    set_m1(0, 0, 0, '0, CTI_CLASSIC);
    s_ack = 1'b0; s_rdat = 32'hDEAD_BEEF;
    do_reset();
    check("reset_gnt", 128'(gnt), 128'(2'b00));

    // Single master classic read
    m1_ack_any = 1'b0;
    set_m0(1, 1, 0, 32'h7C8, CTI_CLASSIC);
    wait_ack(0, 10, n, ok);
    check("t1_ack_seen", 128'(ok), 128'(1'b1));
    check("t1_ack_cycle", 128'(n), 128'(3));
    check("t1_rdata", 128'(seen_rdat0), 128'(32'hDEAD_BEEF));
    set_m0(0, 0, 0, '0, CTI_CLASSIC);
    step(); step();
    check("t1_m1_never_acked", 128'(m1_ack_any), 128'(1'b0));

    // Simultaneous request after reset: M0 first, one idle cycle, then M1
    do_reset();
    set_m0(1, 1, 0, 32'h040, CTI_CLASSIC);
    set_m1(1, 1, 1, 32'h200, CTI_CLASSIC);
    step();
    check("t2_m0_first", 128'(gnt), 128'(2'b01));
    wait_ack(0, 10, n, ok);
    check("t2_m0_ack", 128'(ok), 128'(1'b1));
    set_m0(0, 0, 0, '0, CTI_CLASSIC);
    step();
    check("t2_idle_gap", 128'(gnt), 128'(2'b00));
    step();
    check("t2_then_m1", 128'(gnt), 128'(2'b10));
    wait_ack(1, 10, n, ok);
    check("t2_m1_ack", 128'(ok), 128'(1'b1));
    set_m1(0, 0, 0, '0, CTI_CLASSIC);
    step(); step();

    // Burst lock: M1 4-beat INCR burst ending EOB, M0 requesting throughout
    s_rdat = 32'hCAFE_0000;
    set_m1(1, 1, 1, 32'h100, CTI_INCR);
    step();
    check("t3_m1_granted", 128'(gnt), 128'(2'b10));
    set_m0(1, 1, 0, 32'h400, CTI_CLASSIC);
    beats = 0; viol = 0;
    for (int i = 0; i < 40 && beats < 4; i++) begin
      step();
      if (seen_ack1) begin
        beats++;
        m1_adr  = m1_adr + 4;
        m1_wdat = m1_wdat + 1;
        m1_cti  = (beats == 3) ? CTI_EOB : CTI_INCR;
      end
      if (beats < 4 && gnt != 2'b10) viol++;
    end
    check("t3_beats", 128'(beats), 128'(4));
    check("t3_m0_blocked", 128'(viol), 128'(0));
    set_m1(0, 0, 0, '0, CTI_CLASSIC);
    check("t3_idle_after_eob", 128'(gnt), 128'(2'b00));
    step();
    check("t3_gnt0_two_after_eob", 128'(gnt), 128'(2'b01));
    wait_ack(0, 10, n, ok);
    set_m0(0, 0, 0, '0, CTI_CLASSIC);
    step(); step();

    // Fairness: continuous single-beat EOB requests from both masters
    do_reset();
    set_m0(1, 1, 0, 32'h800, CTI_EOB);
    set_m1(1, 1, 1, 32'h900, CTI_EOB);
    prev_gnt = gnt; tenures = 0;
    for (int i = 0; i < 200 && tenures < 20; i++) begin
      step();
      if (prev_gnt == 2'b00 && gnt != 2'b00) begin
        seq[tenures] = (gnt == 2'b10) ? 1 : 0;
        tenures++;
      end
      prev_gnt = gnt;
    end
    check("t4_tenures", 128'(tenures), 128'(20));
    cnt0 = 0; cnt1 = 0; alt_err = 0;
    for (int i = 0; i < tenures; i++) begin
      if (seq[i] == 0) cnt0++; else cnt1++;
      if (seq[i] != i % 2) alt_err++;
    end
    check("t4_m0_grants", 128'(cnt0), 128'(10));
    check("t4_m1_grants", 128'(cnt1), 128'(10));
    check("t4_alternation", 128'(alt_err), 128'(0));
    set_m0(0, 0, 0, '0, CTI_CLASSIC);
    set_m1(0, 0, 0, '0, CTI_CLASSIC);
    step(); step();

    // Asynchronous reset between edges in the middle of a burst
    set_m0(1, 1, 1, 32'h300, CTI_INCR);
    repeat (4) step();
    check("t5_in_burst", 128'(gnt), 128'(2'b01));
    #2 rst_n = 1'b0;
    #1;
    check("t5_cyc_async", 128'(s_cyc), 128'(1'b0));
    check("t5_gnt_async", 128'(gnt), 128'(2'b00));
    set_m0(0, 0, 0, '0, CTI_CLASSIC);
    s_ack = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Slave never acknowledges
    slave_on = 1'b0;
    set_m0(1, 1, 0, 32'hA00, CTI_CLASSIC);
    step();
    check("t6_granted", 128'(gnt), 128'(2'b01));
`ifdef ZAP_WB_ARB_WDOG_EN
    n = 0; ok = 1'b0;
    while (n < 40) begin
      step();
      n++;
      if (seen_err0) begin ok = 1'b1; break; end
    end
    check("t6_err_seen", 128'(ok), 128'(1'b1));
    check("t6_err_at_16th_stall", 128'(n), 128'(16));
    check("t6_trip_set", 128'(trip), 128'(1'b1));
    check("t6_idle_after_err", 128'(gnt), 128'(2'b00));
    step();
    check("t6_regrant", 128'(gnt), 128'(2'b01));
    check("t6_trip_sticky", 128'(trip), 128'(1'b1));
`else
    err_any = 1'b0;
    repeat (40) begin
      step();
      if (seen_err0) err_any = 1'b1;
    end
    check("t6_no_err", 128'(err_any), 128'(1'b0));
    check("t6_still_granted", 128'(gnt), 128'(2'b01));
    check("t6_no_trip", 128'(trip), 128'(1'b0));
`endif
    set_m0(0, 0, 0, '0, CTI_CLASSIC);
    slave_on = 1'b1;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
